// File: rtl/mem_pkg.sv
// Shared types for the memory/writeback stage: access sizes, FSM states, WB bus.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } mem_state_t;

  // The destination index lives beside this bus because its width is a module parameter.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_src;
    logic        misalign;
    logic [31:0] alu_result;
    logic [31:0] read_data;
  } wb_bus_t;

  // The reserved size code falls through to a full-word enable.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      BYTE:    lane_be = 4'b0001 << lo;
      HALF:    lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Combinational byte-lane logic: enables, store replication, load extension, alignment check.
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    be       = lane_be(size, addr_lo);
    shifted  = load_raw >> {addr_lo, 3'b000};
    wdata    = store_data;
    load_ext = load_raw;
    misalign = 1'b0;
    case (size)
      BYTE: begin
        wdata    = {4{store_data[7:0]}};
        load_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        wdata    = {2{store_data[15:0]}};
        load_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        misalign = addr_lo[0];
      end
      default: misalign = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage with req/ack data port and MEM/WB register; 1 cycle M->W plus N memory wait cycles.
// While a request is outstanding stall_m holds M and W receives bubbles; flush kills WB capture only.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          REG_W   = 4,
  parameter logic [31:0] INC_VAL = 32'd1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_m,
  input  logic [31:0]       alu_result_m,
  input  logic [31:0]       write_data_m,
  input  logic [REG_W-1:0]  wa3_m,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic              pc_src_m,
  input  logic              mem_write_m,
  input  logic              plus_one_m,
  input  logic [1:0]        size_m,
  input  logic              signed_m,
  input  logic              flush_m,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              valid_w,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic              pc_src_w,
  output logic              misalign_w,
  output logic [31:0]       alu_result_w,
  output logic [31:0]       read_data_w,
  output logic [REG_W-1:0]  wa3_w
);

  mem_state_t        state_q, state_d;
  wb_bus_t           wb_q, wb_d, m_wb, lat_wb;
  logic [REG_W-1:0]  wa3_q, wa3_d, m_wa3, lat_wa3;
  logic [ADDR_W-1:0] m_addr, lat_addr, addr_c;
  logic [31:0]       store_sd, lat_wdata, wdata_c;
  logic [3:0]        lat_be, be_c;
  logic [1:0]        lat_size;
  logic              lat_we, lat_signed, we_c, req_c, stall_c, latch_en;
  logic              idle, m_acc, mem_op;
  logic [1:0]        ln_size, ln_lo;
  logic              ln_sign, ln_misalign;
  logic [3:0]        ln_be;
  logic [31:0]       ln_wdata, ln_load_ext;

  assign idle     = (state_q == IDLE);
  assign m_addr   = alu_result_m[ADDR_W-1:0];
  assign store_sd = write_data_m + (plus_one_m ? INC_VAL : 32'd0);

  // Outside IDLE the lane decodes the held access so load data is extended correctly.
  assign ln_size = idle ? size_m : lat_size;
  assign ln_lo   = idle ? m_addr[1:0] : lat_addr[1:0];
  assign ln_sign = idle ? signed_m : lat_signed;

  mem_lane u_lane (
    .size       (ln_size),
    .addr_lo    (ln_lo),
    .sign_ext   (ln_sign),
    .store_data (store_sd),
    .load_raw   (mem_rdata),
    .be         (ln_be),
    .wdata      (ln_wdata),
    .load_ext   (ln_load_ext),
    .misalign   (ln_misalign)
  );

  assign m_acc  = valid_m & (mem_to_reg_m | mem_write_m);
  assign mem_op = m_acc & ~ln_misalign;
  assign m_wa3  = valid_m ? wa3_m : '0;

  always_comb begin
    m_wb = '0;
    if (valid_m) begin
      m_wb.valid      = 1'b1;
      m_wb.reg_write  = reg_write_m & ~(m_acc & ln_misalign);
      m_wb.mem_to_reg = mem_to_reg_m;
      m_wb.pc_src     = pc_src_m;
      m_wb.misalign   = m_acc & ln_misalign;
      m_wb.alu_result = alu_result_m;
    end
  end

  always_comb begin
    state_d  = state_q;
    wb_d     = '0;
    wa3_d    = '0;
    latch_en = 1'b0;
    stall_c  = 1'b0;
    req_c    = 1'b0;
    we_c     = mem_write_m;
    addr_c   = {m_addr[ADDR_W-1:2], 2'b00};
    wdata_c  = ln_wdata;
    be_c     = ln_be;
    case (state_q)
      IDLE: begin
        req_c   = mem_op & ~flush_m;
        stall_c = mem_op & ~mem_ack & ~flush_m;
        if (!flush_m) begin
          if (!mem_op || mem_ack) begin
            wb_d           = m_wb;
            wb_d.read_data = (mem_op && mem_to_reg_m) ? ln_load_ext : 32'd0;
            wa3_d          = m_wa3;
          end else begin
            latch_en = 1'b1;
            state_d  = WAIT;
          end
        end
      end
      WAIT, DRAIN: begin
        req_c   = 1'b1;
        we_c    = lat_we;
        addr_c  = {lat_addr[ADDR_W-1:2], 2'b00};
        wdata_c = lat_wdata;
        be_c    = lat_be;
        stall_c = ~mem_ack;
        if (mem_ack) begin
          state_d = IDLE;
          // A flush on the ack cycle still lets the bus finish but suppresses the result.
          if (state_q == WAIT && !flush_m) begin
            wb_d           = lat_wb;
            wb_d.read_data = lat_wb.mem_to_reg ? ln_load_ext : 32'd0;
            wa3_d          = lat_wa3;
          end
        end else if (flush_m) begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wb_q       <= '0;
      wa3_q      <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_we     <= 1'b0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_wb     <= '0;
      lat_wa3    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      wa3_q   <= wa3_d;
      if (latch_en) begin
        lat_addr   <= m_addr;
        lat_wdata  <= ln_wdata;
        lat_be     <= ln_be;
        lat_we     <= mem_write_m;
        lat_size   <= size_m;
        lat_signed <= signed_m;
        lat_wb     <= m_wb;
        lat_wa3    <= m_wa3;
      end
    end
  end

  // Request and stall are combinational, so reset must mask them immediately.
  assign mem_req   = req_c & ~reset;
  assign stall_m   = stall_c & ~reset;
  assign mem_we    = we_c;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;
  assign mem_be    = be_c;

  assign valid_w      = wb_q.valid;
  assign reg_write_w  = wb_q.reg_write;
  assign mem_to_reg_w = wb_q.mem_to_reg;
  assign pc_src_w     = wb_q.pc_src;
  assign misalign_w   = wb_q.misalign;
  assign alu_result_w = wb_q.alu_result;
  assign read_data_w  = wb_q.read_data;
  assign wa3_w        = wa3_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus random checks of mem_wb_stage against an arithmetic model of the access rules.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_m = 1'b0;
  logic [31:0] alu_result_m = '0;
  logic [31:0] write_data_m = '0;
  logic [3:0]  wa3_m = '0;
  logic        reg_write_m = 1'b0, mem_to_reg_m = 1'b0, pc_src_m = 1'b0;
  logic        mem_write_m = 1'b0, plus_one_m = 1'b0, signed_m = 1'b0, flush_m = 1'b0;
  logic [1:0]  size_m = '0;
  logic        stall_m, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        valid_w, reg_write_w, mem_to_reg_w, pc_src_w, misalign_w;
  logic [31:0] alu_result_w, read_data_w;
  logic [3:0]  wa3_w;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    int          kind;     // 0 = non-memory, 1 = load, 2 = store
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic        plus1;
    logic [3:0]  wa3;
    logic        rw;
    logic        pcs;
  } op_t;

  always #5 clock = ~clock;

  mem_wb_stage dut (
    .clock(clock), .reset(reset), .valid_m(valid_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .wa3_m(wa3_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m), .pc_src_m(pc_src_m), .mem_write_m(mem_write_m),
    .plus_one_m(plus_one_m), .size_m(size_m), .signed_m(signed_m), .flush_m(flush_m),
    .stall_m(stall_m), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
    .pc_src_w(pc_src_w), .misalign_w(misalign_w), .alu_result_w(alu_result_w),
    .read_data_w(read_data_w), .wa3_w(wa3_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic v, input int kind, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [1:0] size, input logic sgn,
                             input logic p1, input logic [3:0] wa3, input logic rw, input logic pcs);
    op_t o;
    o.valid = v; o.kind = kind; o.addr = addr; o.wdata = wd; o.size = size;
    o.sgn = sgn; o.plus1 = p1; o.wa3 = wa3; o.rw = rw; o.pcs = pcs;
    return o;
  endfunction

  task automatic drive(input op_t o);
    valid_m      = o.valid;
    alu_result_m = o.addr;
    write_data_m = o.wdata;
    wa3_m        = o.wa3;
    reg_write_m  = o.rw;
    mem_to_reg_m = (o.kind == 1);
    mem_write_m  = (o.kind == 2);
    pc_src_m     = o.pcs;
    plus_one_m   = o.plus1;
    size_m       = o.size;
    signed_m     = o.sgn;
  endtask

  // Called just after a rising edge; returns just after the edge on which the op reaches W.
  task automatic run_op(input op_t o, input int nwait, input int flush_at, input logic [31:0] rdata);
    logic [1:0]  lo;
    int          sz;
    logic        acc, mis, req, flushed, live;
    logic [31:0] sd, ebe, ewd, v;
    lo      = o.addr[1:0];
    sz      = (o.size == 2'd3) ? 2 : int'(o.size);
    acc     = o.valid && (o.kind != 0);
    mis     = acc && ((sz == 1 && lo[0]) || (sz == 2 && lo != 2'd0));
    req     = acc && !mis && (flush_at != 0);
    flushed = (flush_at == 0) || (req && flush_at > 0);
    live    = o.valid && !flushed;
    sd      = o.wdata + (o.plus1 ? 32'd1 : 32'd0);
    if (sz == 0) begin
      ebe = 32'd1 << lo;
      ewd = (sd & 32'hFF) * 32'h01010101;
      v   = (rdata >> (8 * lo)) & 32'hFF;
      if (o.sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      ebe = lo[1] ? 32'd12 : 32'd3;
      ewd = (sd & 32'hFFFF) * 32'h00010001;
      v   = (rdata >> (8 * lo)) & 32'hFFFF;
      if (o.sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      ebe = 32'd15;
      ewd = sd;
      v   = rdata;
    end
    drive(o);
    for (int k = 0; k < 64; k++) begin
      flush_m   = (k == flush_at);
      mem_ack   = req ? (k == nwait) : 1'($urandom_range(0, 1));
      mem_rdata = (req && k == nwait) ? rdata : $urandom;
      @(negedge clock);
      chk("mem_req", mem_req, req);
      chk("stall_m", stall_m, req && (k < nwait));
      if (req) begin
        chk("mem_addr", mem_addr, o.addr & 32'hFFFFFFFC);
        chk("mem_be", mem_be, ebe);
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_we", mem_we, o.kind == 2);
      end
      @(posedge clock);
      #1;
      if (req && k < nwait) begin
        chk("w_bubble", valid_w, 0);
      end else begin
        chk("valid_w", valid_w, live);
        chk("reg_write_w", reg_write_w, live && o.rw && !mis);
        chk("mem_to_reg_w", mem_to_reg_w, live && o.kind == 1);
        chk("pc_src_w", pc_src_w, live && o.pcs);
        chk("misalign_w", misalign_w, live && mis);
        chk("alu_result_w", alu_result_w, live ? o.addr : 32'd0);
        chk("wa3_w", wa3_w, live ? o.wa3 : 4'd0);
        chk("read_data_w", read_data_w, (live && o.kind == 1 && !mis) ? v : 32'd0);
        break;
      end
    end
    flush_m = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    op_t o;
    int  nw, fa;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid_w", valid_w, 0);
    chk("rst_reg_write_w", reg_write_w, 0);
    chk("rst_alu_result_w", alu_result_w, 0);
    chk("rst_read_data_w", read_data_w, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall_m", stall_m, 0);
    reset = 1'b0;

    run_op(mk(1, 1, 32'h100, 0, 2'd2, 0, 0, 4'd3, 1, 0), 2, -1, 32'hDEADBEEF);
    run_op(mk(1, 1, 32'h103, 0, 2'd0, 1, 0, 4'd4, 1, 0), 0, -1, 32'h80123456);
    run_op(mk(1, 1, 32'h103, 0, 2'd0, 0, 0, 4'd4, 1, 0), 0, -1, 32'h80123456);
    run_op(mk(1, 2, 32'h202, 32'h0000FFFF, 2'd1, 0, 1, 4'd0, 0, 0), 1, -1, 32'h0);
    run_op(mk(1, 1, 32'h101, 0, 2'd2, 0, 0, 4'd7, 1, 0), 0, -1, 32'h0);
    run_op(mk(1, 1, 32'h400, 0, 2'd2, 0, 0, 4'd9, 1, 1), 4, 2, 32'hCAFEF00D);
    run_op(mk(1, 0, 32'h55, 0, 2'd3, 0, 0, 4'd2, 1, 1), 0, -1, 32'h0);
    run_op(mk(1, 1, 32'h106, 0, 2'd1, 1, 0, 4'd6, 1, 0), 1, -1, 32'h9ABC0000);

    // Reset while a word load is waiting on the bus.
    o = mk(1, 1, 32'h300, 0, 2'd2, 0, 0, 4'd5, 1, 0);
    drive(o);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_wait_pre_req", mem_req, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_wait_req", mem_req, 0);
    chk("rst_wait_stall", stall_m, 0);
    chk("rst_wait_valid_w", valid_w, 0);
    chk("rst_wait_alu_w", alu_result_w, 0);
    valid_m = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    run_op(o, 1, -1, 32'h12345678);

    for (int i = 0; i < 300; i++) begin
      o = mk($urandom_range(0, 9) != 0, int'($urandom_range(0, 2)), $urandom, $urandom,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nw = int'($urandom_range(0, 3));
      fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nw)) : -1;
      run_op(o, nw, fa, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised memory stage with integrated MEM/WB pipeline register for the pipelined ARM core. Adds a variable-latency data-memory handshake (req/ack), byte/halfword/word accesses with store lane steering and load extension, a store-data increment mode, upstream stall generation and flush handling. It sits between the execute/memory pipe register and the writeback mux.

## Interface
- `ADDR_W`, default 32: data address width.
- `REG_W`, default 4: destination register index width (WA3).
- `INC_VAL`, default 1: constant added to store data when `plus_one_m`=1.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `valid_m` in 1: M-stage holds a live instruction.
- `alu_result_m` in 32: ALU result, which is also the memory address (low `ADDR_W` bits).
- `write_data_m` in 32: store data (register Rd).
- `wa3_m` in REG_W: destination register.
- `reg_write_m`, `mem_to_reg_m`, `pc_src_m`, `mem_write_m`, `plus_one_m` in 1: control.
- `size_m` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved, treated as word.
- `signed_m` in 1: sign-extend loads.
- `flush_m` in 1: kill the instruction in M.
- `stall_m` out 1: hold the upstream pipe.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write request.
- `mem_addr` out ADDR_W: word-aligned address (low 2 bits zero).
- `mem_wdata` out 32: lane-steered store data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: request completes this cycle.
- `mem_rdata` in 32: valid when `mem_ack`=1.
- `valid_w`, `reg_write_w`, `mem_to_reg_w`, `pc_src_w`, `misalign_w` out 1: WB control.
- `alu_result_w` out 32: ALU result in WB.
- `read_data_w` out 32: extended load data in WB.
- `wa3_w` out REG_W: destination register in WB.

## Operation
- **Memory op**: `valid_m & (mem_to_reg_m | mem_write_m)` and not misaligned.
- **Misaligned**: half with addr[0]=1, or word with addr[1:0]≠0. No request is issued. The instruction passes in one cycle with `misalign_w`=1 and `reg_write_w`=0.
- **Store data**: `sd = write_data_m + (plus_one_m ? INC_VAL : 0)`, mod 2^32.
  - Byte: `sd[7:0]` replicated ×4, `mem_be` = one-hot at lane addr[1:0].
  - Half: `sd[15:0]` replicated ×2, `mem_be` = 0011 or 1100 by addr[1].
  - Word: `sd` unchanged, `mem_be` = 1111.
- **Loads**: `mem_be` is computed the same way. The selected lane is shifted to bit 0, then zero- or sign-extended according to `signed_m`.
- **FSM states**:
  - **IDLE**: drives the request combinationally from M inputs when a memory op is present.
    - `mem_ack`=1 in the same cycle: the access completes in zero wait; stay in IDLE.
    - Otherwise: latch addr, wdata, be, we, size, signed and WB fields, then go to WAIT.
  - **WAIT**: `mem_req` is held from the latched values.
    - On `mem_ack`: load the WB register and go to IDLE.
    - If `flush_m` is sampled in WAIT: go to DRAIN.
  - **DRAIN**: the request is still held. On `mem_ack`, discard the data, write a bubble (`valid_w`=0) and go to IDLE.
- **Non-memory ops and bubbles**: pass to WB in one cycle.
- **`flush_m` in IDLE**: the WB register captures a bubble. If the flushed instruction was a memory op, no request is issued.
- **`flush_m` priority**: `flush_m` overrides `mem_ack` only for the WB capture. A bus transaction in progress always completes.

## Timing
- **Reset**: all WB outputs are 0, `mem_req`=0 and the state is IDLE. Latched request registers are 0.
- **Latency**:
  - Non-memory op: 1 cycle M→W.
  - Memory op: 1 + N cycles, where N is the number of wait cycles before `mem_ack`.
- **`stall_m`**:
  - IDLE: `mem_op & ~mem_ack & ~flush_m`.
  - WAIT and DRAIN: `~mem_ack`.
- **While `stall_m`=1**: the WB register loads a bubble each cycle, so the instruction appears once in W.
- **Request outputs**: `mem_addr`, `mem_wdata`, `mem_be` and `mem_we` are stable from request assertion until ack. `mem_ack` with `mem_req`=0 is ignored.
- **Reset mid-WAIT**: return to IDLE immediately and drop `mem_req`. The memory side must tolerate an abandoned request.

## Structure
- **Package `mem_pkg`**:
  - `size_t` enum: BYTE, HALF, WORD.
  - `mem_state_t` enum: IDLE, WAIT, DRAIN.
  - `wb_bus_t` packed struct of the WB fields.
- **Sub-module `mem_lane`** (combinational): size + addr[1:0] + data → `mem_be`, steered store data, extended load data, misalign flag.
- **FSM and MEM/WB register**: stay in `mem_wb_stage`.

## Test plan
- **Word load, 2 wait states**: addr 0x100, rdata 0xDEADBEEF, ack on 3rd cycle → `stall_m` high 2 cycles, `read_data_w`=0xDEADBEEF, `valid_w` for 1 cycle.
- **Signed byte load**: addr 0x103, rdata 0x80xxxxxx, zero-wait → `mem_be`=1000, `read_data_w`=0xFFFFFF80. With `signed_m`=0 → 0x00000080.
- **Halfword store with `plus_one_m`**: data 0x0000FFFF, addr 0x202 → wdata 0x00000000 replicated, `mem_be`=1100, `mem_addr`=0x200.
- **Misaligned word**: addr 0x101 → no `mem_req`, `misalign_w`=1, `reg_write_w`=0 next cycle.
- **Flush during WAIT**: flush at cycle 2, ack at cycle 4 → state DRAIN, `mem_req` held until ack, `valid_w` stays 0, `stall_m` drops after ack.
- **Reset asserted in WAIT**: `mem_req`=0 and all W outputs 0 immediately. The next op issues normally.
